// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, prefetches sequential words into a small FIFO and
// loads the instruction register on IR_ld. At most one memory request is in flight.
module inst_fetch_unit #(
  parameter int unsigned PC_W     = 7,
  parameter int unsigned INST_W   = 16,
  parameter int unsigned PF_DEPTH = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              PC_clr,
  input  logic              PC_up,
  input  logic              IR_ld,
  output logic [PC_W-1:0]   IM_Addr,
  output logic              IM_Rd,
  input  logic [INST_W-1:0] IM_Data,
  input  logic              IM_Valid,
  output logic [INST_W-1:0] Inst,
  output logic [PC_W-1:0]   PC,
  output logic              IR_Valid,
  output logic              Stall
);

  localparam int unsigned PtrW = 2;
  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] Depth   = CntW'(PF_DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(PF_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} req_state_e;

  req_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, fp_q, fp_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              ir_valid_q, ir_valid_d;
  logic [INST_W-1:0] fifo_q [4];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              fifo_empty, outstanding, issue, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign fifo_empty  = (count_q == '0);
  assign outstanding = (state_q == StWait);
  // Gated by Reset so no request is presented while the block is held in reset.
  assign issue = Reset && (state_q == StIdle) && !PC_clr &&
                 ((count_q + CntW'(outstanding)) < Depth);
  assign push  = (state_q == StWait) && IM_Valid && !PC_clr;
  assign pop   = IR_ld && !fifo_empty && !PC_clr;

  assign Stall    = IR_ld && fifo_empty;
  assign IM_Rd    = issue;
  assign IM_Addr  = fp_q;
  assign Inst     = inst_q;
  assign PC       = pc_q;
  assign IR_Valid = ir_valid_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (issue) state_d = StWait;
      StWait: begin
        if (IM_Valid)    state_d = StIdle;
        else if (PC_clr) state_d = StDiscard;
      end
      StDiscard: if (IM_Valid) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    fp_d       = fp_q;
    inst_d     = inst_q;
    ir_valid_d = ir_valid_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (PC_clr) begin
      pc_d       = '0;
      fp_d       = '0;
      ir_valid_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) fp_d = fp_q + PC_W'(1);
      if (PC_up && !Stall) pc_d = pc_q + PC_W'(1);
      if (IR_ld) begin
        ir_valid_d = !fifo_empty;
        if (!fifo_empty) inst_d = fifo_q[rd_ptr_q];
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      fp_q       <= '0;
      inst_q     <= '0;
      ir_valid_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fp_q       <= fp_d;
      inst_q     <= inst_d;
      ir_valid_q <= ir_valid_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_q[wr_ptr_q] <= IM_Data;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a latency-programmable memory model feeds two
// instances (PC_W=7 and PC_W=3); only the selected one is out of reset at a time.
module tb_inst_fetch_unit;

  logic        Clock = 1'b0;
  logic        rst_a, rst_b, sel;
  logic        PC_clr, PC_up, IR_ld, IM_Valid;
  logic [15:0] IM_Data;

  logic [6:0]  addr_a, pc_a;
  logic [2:0]  addr_b, pc_b;
  logic [15:0] inst_a, inst_b;
  logic        rd_a, rd_b, iv_a, iv_b, st_a, st_b;

  logic [6:0]  obs_addr, obs_pc;
  logic [15:0] obs_inst;
  logic        obs_rd, obs_iv, obs_st;

  always #5 Clock = ~Clock;

  inst_fetch_unit #(.PC_W(7), .INST_W(16), .PF_DEPTH(2)) dut (
    .Clock(Clock), .Reset(rst_a), .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .IM_Addr(addr_a), .IM_Rd(rd_a), .IM_Data(IM_Data), .IM_Valid(IM_Valid),
    .Inst(inst_a), .PC(pc_a), .IR_Valid(iv_a), .Stall(st_a)
  );

  inst_fetch_unit #(.PC_W(3), .INST_W(16), .PF_DEPTH(2)) dut3 (
    .Clock(Clock), .Reset(rst_b), .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .IM_Addr(addr_b), .IM_Rd(rd_b), .IM_Data(IM_Data), .IM_Valid(IM_Valid),
    .Inst(inst_b), .PC(pc_b), .IR_Valid(iv_b), .Stall(st_b)
  );

  assign obs_addr = sel ? {4'b0, addr_b} : addr_a;
  assign obs_pc   = sel ? {4'b0, pc_b} : pc_a;
  assign obs_inst = sel ? inst_b : inst_a;
  assign obs_rd   = sel ? rd_b : rd_a;
  assign obs_iv   = sel ? iv_b : iv_a;
  assign obs_st   = sel ? st_b : st_a;

  int n_checks = 0;
  int n_pass   = 0;
  int lat, mem_cnt, cyc;
  logic [6:0]  mem_addr, last_addr;
  logic        last_rd;
  logic [15:0] exp_inst_q [$];
  logic [6:0]  exp_addr_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock: sample requests before the edge, then advance the memory model.
  task automatic tick();
    #2;
    last_rd   = obs_rd;
    last_addr = obs_addr;
    if (obs_rd) begin
      if (exp_addr_q.size() > 0) check("im_addr", 32'(obs_addr), 32'(exp_addr_q.pop_front()));
      mem_cnt  = lat;
      mem_addr = obs_addr;
    end
    @(posedge Clock);
    #1;
    IM_Valid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        IM_Valid = 1'b1;
        IM_Data  = 16'hA000 + {9'b0, mem_addr};
      end
    end
    cyc++;
  endtask

  task automatic reset_dut(input logic which);
    rst_a = 1'b0; rst_b = 1'b0; sel = which;
    PC_clr = 1'b0; PC_up = 1'b0; IR_ld = 1'b0;
    IM_Valid = 1'b0; mem_cnt = 0;
    @(posedge Clock);
    #1;
    if (which) rst_b = 1'b1;
    else       rst_a = 1'b1;
  endtask

  task automatic load_one(input logic [15:0] exp_word, input logic [6:0] exp_pc, input string tag);
    IR_ld = 1'b1; PC_up = 1'b1;
    exp_inst_q.push_back(exp_word);
    tick();
    IR_ld = 1'b0; PC_up = 1'b0;
    check({tag, "_inst"}, 32'(obs_inst), 32'(exp_inst_q.pop_front()));
    check({tag, "_irv"}, 32'(obs_iv), 32'd1);
    check({tag, "_pc"}, 32'(obs_pc), 32'(exp_pc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_rd, second_rd, nrd, loads;
    logic found, vin;
    cyc = 0; lat = 1; IM_Data = '0;

    // Reset values while held in reset.
    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
    PC_clr = 1'b0; PC_up = 1'b0; IR_ld = 1'b0; IM_Valid = 1'b0; mem_cnt = 0;
    @(posedge Clock); #2;
    check("rst_inst", 32'(obs_inst), 32'h0);
    check("rst_irv", 32'(obs_iv), 32'd0);
    check("rst_pc", 32'(obs_pc), 32'd0);
    check("rst_rd", 32'(obs_rd), 32'd0);
    check("rst_addr", 32'(obs_addr), 32'd0);

    // 1: prefetch two words after reset release.
    reset_dut(1'b0);
    exp_addr_q.push_back(7'd0); exp_addr_q.push_back(7'd1);
    first_rd = -1; second_rd = -1; nrd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_rd) begin
        nrd++;
        if (first_rd < 0) first_rd = cyc;
        else if (second_rd < 0) second_rd = cyc;
      end
    end
    check("t1_nrd", 32'(nrd), 32'd2);
    check("t1_gap", 32'(second_rd - first_rd), 32'd2);
    #1;
    check("t1_idle_rd", 32'(obs_rd), 32'd0);
    check("t1_fp", 32'(obs_addr), 32'd2);

    // 2: single load, then refill fetches address 2.
    IR_ld = 1'b1; PC_up = 1'b1; #1;
    check("t2_stall", 32'(obs_st), 32'd0);
    load_one(16'hA000, 7'd1, "t2");
    exp_addr_q.push_back(7'd2);
    for (int i = 0; i < 4; i++) tick();
    check("t2_next_rd", 32'(exp_addr_q.size()), 32'd0);

    // 3: latency 5, loads attempted on an empty FIFO stall, no bypass on arrival.
    lat = 5;
    reset_dut(1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      IR_ld = 1'b1; PC_up = 1'b1; #1;
      vin = IM_Valid;
      check("t3_stall", 32'(obs_st), 32'd1);
      tick();
      check("t3_inst_hold", 32'(obs_inst), 32'h0);
      check("t3_irv", 32'(obs_iv), 32'd0);
      check("t3_pc_hold", 32'(obs_pc), 32'd0);
      if (vin) found = 1'b1;
    end
    check("t3_arrived", 32'(found), 32'd1);
    #1;
    check("t3_stall_clear", 32'(obs_st), 32'd0);
    load_one(16'hA000, 7'd1, "t3");

    // 4: PC_clr while the request for address 4 is in flight.
    lat = 3;
    reset_dut(1'b0);
    found = 1'b0;
    IR_ld = 1'b1; PC_up = 1'b1;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (last_rd && last_addr == 7'd4) found = 1'b1;
    end
    check("t4_rd4_seen", 32'(found), 32'd1);
    IR_ld = 1'b0; PC_up = 1'b0; PC_clr = 1'b1;
    tick();
    PC_clr = 1'b0;
    check("t4_pc", 32'(obs_pc), 32'd0);
    check("t4_irv", 32'(obs_iv), 32'd0);
    #1;
    check("t4_discard_rd", 32'(obs_rd), 32'd0);
    check("t4_fp", 32'(obs_addr), 32'd0);
    exp_addr_q.push_back(7'd0);
    for (int i = 0; i < 10; i++) tick();
    check("t4_refetch", 32'(exp_addr_q.size()), 32'd0);
    load_one(16'hA000, 7'd1, "t4");

    // 5: PC_W=3 wrap of PC, fetch address and instruction sequence.
    lat = 1;
    reset_dut(1'b1);
    for (int i = 0; i < 9; i++) begin
      exp_inst_q.push_back(16'hA000 + 16'(i % 8));
      exp_addr_q.push_back(7'(i % 8));
    end
    loads = 0;
    IR_ld = 1'b1; PC_up = 1'b1;
    for (int i = 0; i < 80 && loads < 9; i++) begin
      tick();
      if (obs_iv) begin
        check("t5_inst", 32'(obs_inst), 32'(exp_inst_q.pop_front()));
        check("t5_pc", 32'(obs_pc), 32'((loads + 1) % 8));
        loads++;
      end
    end
    IR_ld = 1'b0; PC_up = 1'b0;
    check("t5_loads", 32'(loads), 32'd9);
    check("t5_addr_q", 32'(exp_addr_q.size()), 32'd0);
    exp_inst_q.delete();
    exp_addr_q.delete();

    // 6: asynchronous reset in WAIT; the late response must be ignored.
    lat = 1;
    reset_dut(1'b0);
    for (int i = 0; i < 6; i++) tick();
    lat = 3;
    load_one(16'hA000, 7'd1, "t6_pre");
    tick();
    #2;
    rst_a = 1'b0;
    #1;
    check("t6_async_inst", 32'(obs_inst), 32'h0);
    check("t6_async_irv", 32'(obs_iv), 32'd0);
    check("t6_async_pc", 32'(obs_pc), 32'd0);
    check("t6_async_rd", 32'(obs_rd), 32'd0);
    check("t6_async_addr", 32'(obs_addr), 32'd0);
    tick();
    tick();
    rst_a = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t6_irv_idle", 32'(obs_iv), 32'd0);
    load_one(16'hA000, 7'd1, "t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
